// File: rtl/bist_pkg.sv
// Shared types and the March C- element table for the single-port RAM BIST.
// Optional build macro: BIST_STOP_ON_FAIL_EN (see sp_ram_march_bist.sv).
package bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } bist_state_e;

  // Phase A issues the read, phase B compares (and optionally writes back).
  typedef enum logic {
    PhA,
    PhB
  } bist_phase_e;

  localparam int unsigned NumElems = 6;
  localparam logic [2:0] LastElem = 3'(NumElems - 1);

  // One March element: walk direction, read/compare, write-back and background selects.
  typedef struct packed {
    logic down;       // 1: DEPTH-1..0, 0: 0..DEPTH-1
    logic has_read;   // element uses a two-cycle read/compare slot
    logic exp_one;    // expected background: 1 = all ones, 0 = all zeros
    logic has_write;  // element writes a background
    logic wr_one;     // written background: 1 = all ones, 0 = all zeros
  } elem_cfg_t;

  // March C-: {Up w0} {Up r0 w1} {Up r1 w0} {Dn r0 w1} {Dn r1 w0} {Up r0}
  function automatic elem_cfg_t elem_cfg(input logic [2:0] idx);
    elem_cfg_t cfg;
    case (idx)
      3'd0:    cfg = '{down: 1'b0, has_read: 1'b0, exp_one: 1'b0, has_write: 1'b1, wr_one: 1'b0};
      3'd1:    cfg = '{down: 1'b0, has_read: 1'b1, exp_one: 1'b0, has_write: 1'b1, wr_one: 1'b1};
      3'd2:    cfg = '{down: 1'b0, has_read: 1'b1, exp_one: 1'b1, has_write: 1'b1, wr_one: 1'b0};
      3'd3:    cfg = '{down: 1'b1, has_read: 1'b1, exp_one: 1'b0, has_write: 1'b1, wr_one: 1'b1};
      3'd4:    cfg = '{down: 1'b1, has_read: 1'b1, exp_one: 1'b1, has_write: 1'b1, wr_one: 1'b0};
      3'd5:    cfg = '{down: 1'b0, has_read: 1'b1, exp_one: 1'b0, has_write: 1'b0, wr_one: 1'b0};
      default: cfg = '0;
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/sp_ram_march_bist_if.sv
// Control/status and RAM-side bus of the March BIST engine.
// master: the BIST engine; slave: system logic plus the RAM behind the test mux.
interface sp_ram_march_bist_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N          = 4
);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  fail;
  logic [N-1:0]          fail_addr;
  logic [2:0]            fail_elem;
  logic [N-1:0]          mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  start,
    input  mem_rdata,
    output busy,
    output done,
    output fail,
    output fail_addr,
    output fail_elem,
    output mem_addr,
    output mem_we,
    output mem_wdata
  );

  modport slave (
    output start,
    output mem_rdata,
    input  busy,
    input  done,
    input  fail,
    input  fail_addr,
    input  fail_elem,
    input  mem_addr,
    input  mem_we,
    input  mem_wdata
  );

endinterface

// File: rtl/bist_addr_gen.sv
// Loadable up/down address counter for the March walk; `last` flags the final
// address in the current direction.
module bist_addr_gen #(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         load_down,
  input  logic         step,
  input  logic         down,
  output logic [N-1:0] addr,
  output logic         last
);

  localparam logic [N-1:0] TopAddr = N'(DEPTH - 1);
  localparam logic [N-1:0] One     = N'(1);

  logic [N-1:0] addr_q, addr_d;

  // Load takes priority over stepping.
  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_down ? TopAddr : '0;
    end else if (step) begin
      addr_d = down ? (addr_q - One) : (addr_q + One);
    end
  end

  // Address register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  assign last = down ? (addr_q == '0) : (addr_q == TopAddr);

endmodule

// File: rtl/sp_ram_march_bist.sv
// March C- built-in self-test engine for a single-port RAM with registered read data.
// Optional build macro: BIST_STOP_ON_FAIL_EN -- end the run at the first mismatching
// compare and suppress that cycle's write-back.
module sp_ram_march_bist
  import bist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned N          = 4
) (
  input logic                 clk,
  input logic                 rst,
  sp_ram_march_bist_if.master bus
);

  bist_state_e state_q, state_d;
  bist_phase_e phase_q, phase_d;
  logic [2:0]  elem_q, elem_d;
  logic        fail_q, fail_d;
  logic [N-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]  fail_elem_q, fail_elem_d;

  logic [N-1:0] addr;
  logic         addr_last;
  logic         addr_load;
  logic         addr_load_down;
  logic         addr_step;

  elem_cfg_t             cfg;
  elem_cfg_t             next_cfg;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  compare;
  logic                  mismatch;
  logic                  slot_end;

  logic [N-1:0]          mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign cfg      = elem_cfg(elem_q);
  assign next_cfg = elem_cfg(elem_q + 3'd1);
  assign exp_data = cfg.exp_one ? '1 : '0;
  assign compare  = (state_q == StRun) && cfg.has_read && (phase_q == PhB);
  assign mismatch = compare && (bus.mem_rdata != exp_data);
  // E0 has a single-cycle slot; all read elements end their slot in phase B.
  assign slot_end = !cfg.has_read || (phase_q == PhB);

  bist_addr_gen #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (addr_load),
    .load_down (addr_load_down),
    .step      (addr_step),
    .down      (cfg.down),
    .addr      (addr),
    .last      (addr_last)
  );

  // Next-state: start acceptance, slot/element sequencing and first-fail capture.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    elem_d         = elem_q;
    fail_d         = fail_q;
    fail_addr_d    = fail_addr_q;
    fail_elem_d    = fail_elem_q;
    addr_load      = 1'b0;
    addr_load_down = 1'b0;
    addr_step      = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d        = StRun;
          phase_d        = PhA;
          elem_d         = 3'd0;
          fail_d         = 1'b0;
          fail_addr_d    = '0;
          fail_elem_d    = '0;
          addr_load      = 1'b1;
          addr_load_down = 1'b0;
        end
      end
      StRun: begin
        if (!slot_end) begin
          phase_d = PhB;
        end else begin
          phase_d = PhA;
          if (addr_last) begin
            if (elem_q == LastElem) begin
              state_d = StDone;
            end else begin
              elem_d         = elem_q + 3'd1;
              addr_load      = 1'b1;
              addr_load_down = next_cfg.down;
            end
          end else begin
            addr_step = 1'b1;
          end
        end

        if (mismatch) begin
          fail_d = 1'b1;
          if (!fail_q) begin
            fail_addr_d = addr;
            fail_elem_d = elem_q;
          end
`ifdef BIST_STOP_ON_FAIL_EN
          state_d = StDone;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // RAM drive: quiet outside RUN; write in E0 and in phase B of write-back elements.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (state_q == StRun) begin
      mem_addr = addr;
      if (cfg.has_write && slot_end) begin
        mem_we    = 1'b1;
        mem_wdata = cfg.wr_one ? '1 : '0;
      end
`ifdef BIST_STOP_ON_FAIL_EN
      // The run ends at this edge, so the faulty cell is left untouched.
      if (mismatch) begin
        mem_we    = 1'b0;
        mem_wdata = '0;
      end
`endif
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      phase_q     <= PhA;
      elem_q      <= 3'd0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      elem_q      <= elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  assign bus.busy      = (state_q == StRun);
  assign bus.done      = (state_q == StDone);
  assign bus.fail      = fail_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_elem = fail_elem_q;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_we    = mem_we;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_sp_ram_march_bist.sv
// Bench for sp_ram_march_bist: behavioural registered-read RAM with an optional
// stuck-at bit on one address, table of fault scenarios, plus restart/reset sequences.
module tb_sp_ram_march_bist;

  localparam int unsigned DataWidth = 8;
  localparam int unsigned Depth     = 16;
  localparam int unsigned AddrW     = 4;
  localparam int          FullRun   = 11 * Depth;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  sp_ram_march_bist_if #(
    .DATA_WIDTH (DataWidth),
    .N          (AddrW)
  ) bus_if ();

  sp_ram_march_bist #(
    .DATA_WIDTH (DataWidth),
    .DEPTH      (Depth),
    .N          (AddrW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model; the fault masks corrupt the read path of one address.
  logic [DataWidth-1:0] ram [Depth];
  logic [AddrW-1:0]     flt_addr;
  logic [DataWidth-1:0] flt_sa1;
  logic [DataWidth-1:0] flt_sa0;

  always @(posedge clk) begin
    if (bus_if.mem_we) ram[bus_if.mem_addr] <= bus_if.mem_wdata;
    if (bus_if.mem_addr == flt_addr)
      bus_if.mem_rdata <= (ram[bus_if.mem_addr] | flt_sa1) & ~flt_sa0;
    else
      bus_if.mem_rdata <= ram[bus_if.mem_addr];
  end

  typedef struct {
    string            name;
    logic [AddrW-1:0] faddr;
    logic [7:0]       sa1;
    logic [7:0]       sa0;
    int               exp_cycles;
    logic             exp_fail;
    logic [AddrW-1:0] exp_faddr;
    logic [2:0]       exp_felem;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pulse start, then follow the run; optionally pulse start again or drop reset
  // at a given busy cycle (1-based). Returns the number of busy cycles seen.
  task automatic run_bist(input int pulse_at, input int rst_at, output int cycles);
    int c;
    @(negedge clk);
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    check("accept_busy", bus_if.busy, 1);
    check("accept_done", bus_if.done, 0);
    check("accept_fail", bus_if.fail, 0);
    check("first_we", bus_if.mem_we, 1);
    check("first_addr", bus_if.mem_addr, 0);
    c = 1;
    while (c <= 1000) begin
      if (c == pulse_at) bus_if.start = 1'b1;
      if (c == rst_at) begin
        rst = 1'b0;
        #1;
        check("rst_busy", bus_if.busy, 0);
        check("rst_done", bus_if.done, 0);
        check("rst_fail", bus_if.fail, 0);
        check("rst_we", bus_if.mem_we, 0);
        cycles = c;
        return;
      end
      @(posedge clk);
      #1 bus_if.start = 1'b0;
      if (!bus_if.busy) begin
        cycles = c;
        return;
      end
      c++;
    end
    checks++;
    failures++;
    $display("FAIL run_timeout actual=%0d required=%0d", c, FullRun);
    cycles = c;
  endtask

  // Completion checks common to every finished run, then a few idle cycles.
  task automatic check_done(input string tag, input int cycles, input int exp_cycles,
                            input logic exp_fail, input logic [AddrW-1:0] exp_faddr,
                            input logic [2:0] exp_felem);
    check({tag, "_cycles"}, cycles, exp_cycles);
    check({tag, "_done"}, bus_if.done, 1);
    check({tag, "_fail"}, bus_if.fail, exp_fail);
    check({tag, "_fail_addr"}, bus_if.fail_addr, exp_faddr);
    check({tag, "_fail_elem"}, bus_if.fail_elem, exp_felem);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_idle_we"}, bus_if.mem_we, 0);
      check({tag, "_idle_addr"}, bus_if.mem_addr, 0);
    end
    check({tag, "_done_held"}, bus_if.done, 1);
  endtask

  initial begin
    int cyc;
    int stop_e1_5, stop_e2_10, stop_e2_0, stop_e1_15;

`ifdef BIST_STOP_ON_FAIL_EN
    stop_e1_5  = 28;  // E0 16 + E1 slots 0..5
    stop_e2_10 = 70;  // E0 16 + E1 32 + E2 slots 0..10
    stop_e2_0  = 50;
    stop_e1_15 = 48;
`else
    stop_e1_5  = FullRun;
    stop_e2_10 = FullRun;
    stop_e2_0  = FullRun;
    stop_e1_15 = FullRun;
`endif

    vecs[0] = '{"clean",    4'd0,  8'h00, 8'h00, FullRun,    1'b0, 4'd0,  3'd0};
    vecs[1] = '{"a5_sa1b3", 4'd5,  8'h08, 8'h00, stop_e1_5,  1'b1, 4'd5,  3'd1};
    vecs[2] = '{"a10_sa0b0", 4'd10, 8'h00, 8'h01, stop_e2_10, 1'b1, 4'd10, 3'd2};
    vecs[3] = '{"a0_sa0b7", 4'd0,  8'h00, 8'h80, stop_e2_0,  1'b1, 4'd0,  3'd2};
    vecs[4] = '{"a15_sa1b0", 4'd15, 8'h01, 8'h00, stop_e1_15, 1'b1, 4'd15, 3'd1};

    for (int i = 0; i < Depth; i++) ram[i] = '0;
    flt_addr     = '0;
    flt_sa1      = '0;
    flt_sa0      = '0;
    bus_if.start = 1'b1;
    rst          = 1'b0;

    // Reset state, with start held high throughout.
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus_if.busy, 0);
    check("reset_done", bus_if.done, 0);
    check("reset_fail", bus_if.fail, 0);
    check("reset_fail_addr", bus_if.fail_addr, 0);
    check("reset_fail_elem", bus_if.fail_elem, 0);
    check("reset_we", bus_if.mem_we, 0);
    check("reset_addr", bus_if.mem_addr, 0);
    check("reset_wdata", bus_if.mem_wdata, 0);
    @(negedge clk);
    bus_if.start = 1'b0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", bus_if.busy, 0);

    // Fault table.
    for (int v = 0; v < 5; v++) begin
      flt_addr = vecs[v].faddr;
      flt_sa1  = vecs[v].sa1;
      flt_sa0  = vecs[v].sa0;
      run_bist(0, 0, cyc);
      check_done(vecs[v].name, cyc, vecs[v].exp_cycles, vecs[v].exp_fail,
                 vecs[v].exp_faddr, vecs[v].exp_felem);
      if (v == 0) begin
        for (int a = 0; a < Depth; a++) check("clean_ram_zero", ram[a], 0);
      end
    end

    // Restart attempt mid-run is ignored; the run from DONE clears the previous fail.
    flt_addr = '0;
    flt_sa1  = '0;
    flt_sa0  = '0;
    run_bist(40, 0, cyc);
    check_done("restart40", cyc, FullRun, 1'b0, 4'd0, 3'd0);

    // Reset mid-run, then a full clean pass.
    run_bist(0, 50, cyc);
    check("rst50_cycle", cyc, 50);
    @(negedge clk);
    rst = 1'b1;
    run_bist(0, 0, cyc);
    check_done("after_rst", cyc, FullRun, 1'b0, 4'd0, 3'd0);
    for (int a = 0; a < Depth; a++) check("after_rst_ram_zero", ram[a], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
